// File: rtl/powlib_busslvreg.sv
// rtl/powlib_busslvreg.sv - register-file bus slave: beat writes, read-request beats answered on a response stream.
// Optional: define POWLIB_BUSSLVREG_ERRCNT_EN to add a saturating out-of-range beat counter (errcnt).
module powlib_busslvreg #(
  parameter int              B_AW   = 16,
  parameter int              B_DW   = 32,
  parameter logic [B_AW-1:0] B_BASE = 16'h2000,
  parameter int              R      = 4,
  parameter logic [B_DW-1:0] INIT   = '0,
  parameter                  ID     = "BUSSLVREG",
  parameter int              EDBG   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [B_DW-1:0]     rddata,
  input  logic [B_AW-1:0]     rdaddr,
  input  logic                rdvld,
  output logic                rdrdy,
  output logic [B_DW-1:0]     wrdata,
  output logic [B_AW-1:0]     wraddr,
  output logic                wrvld,
  input  logic                wrrdy,
`ifdef POWLIB_BUSSLVREG_ERRCNT_EN
  output logic [7:0]          errcnt,
`endif
  output logic [R*B_DW-1:0]   regout
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [B_AW:0] R_LIM  = (B_AW+1)'(R);
  localparam logic [B_AW:0] R2_LIM = (B_AW+1)'(2 * R);
  localparam logic [IW-1:0] IDX_MASK = IW'(R - 1);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [B_DW-1:0] regs [R];
  logic [B_AW-1:0] off;
  logic [IW-1:0]   idx;
  logic            accept, is_wr, is_rd, is_oor;

  // Modulo subtraction lets a window that straddles 2^B_AW decode correctly.
  assign off    = rdaddr - B_BASE;
  assign idx    = off[IW-1:0] & IDX_MASK;
  assign is_wr  = ({1'b0, off} < R_LIM);
  assign is_rd  = !is_wr && ({1'b0, off} < R2_LIM);
  assign is_oor = !is_wr && !is_rd;

  assign rdrdy  = ~rst && (state == IDLE);
  assign accept = rdvld && rdrdy;
  assign wrvld  = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_rd) state_nxt = RESP;
      RESP: if (wrrdy)           state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrdata <= '0;
      wraddr <= '0;
    end else if (accept && is_rd) begin
      wrdata <= regs[idx];
      wraddr <= rddata[B_AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < R; k++) regs[k] <= INIT;
    end else if (accept && is_wr) begin
      regs[idx] <= rddata;
    end
  end

  always_comb begin
    for (int k = 0; k < R; k++) regout[k*B_DW +: B_DW] = regs[k];
  end

`ifdef POWLIB_BUSSLVREG_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt <= '0;
    end else if (accept && is_oor && (errcnt != 8'hFF)) begin
      errcnt <= errcnt + 8'd1;
    end
  end
`else
  logic unused_oor;
  assign unused_oor = is_oor;
`endif

  // Debug identity hooks have no hardware effect.
  if ((EDBG != 0) && (ID != "")) begin : g_edbg
  end

endmodule

// File: tb/tb_powlib_busslvreg.sv
// tb/tb_powlib_busslvreg.sv - directed self-checking bench for powlib_busslvreg.
module tb_powlib_busslvreg;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  rddata;
  logic [15:0]  rdaddr;
  logic         rdvld;
  logic         rdrdy;
  logic [31:0]  wrdata;
  logic [15:0]  wraddr;
  logic         wrvld;
  logic         wrrdy;
  logic [127:0] regout;
`ifdef POWLIB_BUSSLVREG_ERRCNT_EN
  logic [7:0]   errcnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int xfers = 0;

  powlib_busslvreg dut (
    .clk    (clk),
    .rst    (rst),
    .rddata (rddata),
    .rdaddr (rdaddr),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .wrdata (wrdata),
    .wraddr (wraddr),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
`ifdef POWLIB_BUSSLVREG_ERRCNT_EN
    .errcnt (errcnt),
`endif
    .regout (regout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && wrvld && wrrdy) xfers <= xfers + 1;

  task automatic test_reset;
    rst = 1'b1; rdvld = 1'b0; rddata = '0; rdaddr = '0; wrrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rdrdy !== 1'b0) begin n_err++; $display("FAIL reset_rdrdy cyc %0d: got %b want 0", i, rdrdy); end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wrvld !== 1'b0) begin n_err++; $display("FAIL reset_wrvld: got %b want 0", wrvld); end
    n_cmp++;
    if (regout !== 128'h0) begin n_err++; $display("FAIL reset_regout: got %h want 0", regout); end
    n_cmp++;
    if (rdrdy !== 1'b1) begin n_err++; $display("FAIL reset_release_rdrdy: got %b want 1", rdrdy); end
  endtask

  task automatic test_write;
    rdvld = 1'b1; rdaddr = 16'h2002; rddata = 32'hDEADBEEF;
    @(negedge clk);
    rdvld = 1'b0;
    n_cmp++;
    if (regout[2*32 +: 32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_reg2: got %h want deadbeef", regout[2*32 +: 32]); end
    n_cmp++;
    if (wrvld !== 1'b0) begin n_err++; $display("FAIL write_no_resp: got wrvld %b want 0", wrvld); end
    n_cmp++;
    if (regout[0 +: 32] !== 32'h0) begin n_err++; $display("FAIL write_reg0_untouched: got %h want 0", regout[0 +: 32]); end
  endtask

  task automatic test_read_stall;
    int x0;
    wrrdy = 1'b0;
    rdvld = 1'b1; rdaddr = 16'h2001; rddata = 32'h12345678;
    @(negedge clk);
    rdaddr = 16'h2005; rddata = 32'h0000_4000;
    @(negedge clk);
    rdvld = 1'b0;
    n_cmp++;
    if (wrvld !== 1'b1 || wraddr !== 16'h4000 || wrdata !== 32'h12345678) begin
      n_err++; $display("FAIL read_resp: got vld %b addr %h data %h want 1 4000 12345678", wrvld, wraddr, wrdata);
    end
    x0 = xfers;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wrvld !== 1'b1 || wraddr !== 16'h4000 || wrdata !== 32'h12345678 || rdrdy !== 1'b0) begin
        n_err++; $display("FAIL stall_hold cyc %0d: got vld %b addr %h data %h rdrdy %b", i, wrvld, wraddr, wrdata, rdrdy);
      end
    end
    wrrdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (xfers - x0 !== 1) begin n_err++; $display("FAIL stall_release_xfers: got %0d want 1", xfers - x0); end
    n_cmp++;
    if (wrvld !== 1'b0 || rdrdy !== 1'b1) begin n_err++; $display("FAIL stall_idle: got vld %b rdrdy %b want 0 1", wrvld, rdrdy); end
  endtask

  task automatic test_back_to_back;
    rdvld = 1'b1; rdaddr = 16'h2003; rddata = 32'hA5A5A5A5;
    @(negedge clk);
    n_cmp++;
    if (rdrdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdrdy: got %b want 1", rdrdy); end
    rdaddr = 16'h2007; rddata = 32'h0000_0042;
    @(negedge clk);
    rdvld = 1'b0;
    n_cmp++;
    if (wrvld !== 1'b1 || wrdata !== 32'hA5A5A5A5 || wraddr !== 16'h0042) begin
      n_err++; $display("FAIL b2b_resp: got vld %b data %h addr %h want 1 a5a5a5a5 0042", wrvld, wrdata, wraddr);
    end
    @(negedge clk);
    n_cmp++;
    if (wrvld !== 1'b0) begin n_err++; $display("FAIL b2b_done: got wrvld %b want 0", wrvld); end
  endtask

  task automatic test_out_of_range;
    logic [127:0] exp_regs;
    int x0;
    exp_regs = {32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678, 32'h0};
    x0 = xfers;
    rdvld = 1'b1; rdaddr = 16'h2008; rddata = 32'h1111_1111;
    @(negedge clk);
    n_cmp++;
    if (rdrdy !== 1'b1) begin n_err++; $display("FAIL oor_accept_2008: got rdrdy %b want 1", rdrdy); end
    rdaddr = 16'h1FFF; rddata = 32'h2222_2222;
    @(negedge clk);
    n_cmp++;
    if (rdrdy !== 1'b1) begin n_err++; $display("FAIL oor_accept_1fff: got rdrdy %b want 1", rdrdy); end
    rdvld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (regout !== exp_regs) begin n_err++; $display("FAIL oor_regs: got %h want %h", regout, exp_regs); end
    n_cmp++;
    if (wrvld !== 1'b0 || xfers != x0) begin n_err++; $display("FAIL oor_no_resp: got vld %b xfers %0d want 0 0", wrvld, xfers - x0); end
`ifdef POWLIB_BUSSLVREG_ERRCNT_EN
    n_cmp++;
    if (errcnt !== 8'd2) begin n_err++; $display("FAIL oor_errcnt2: got %0d want 2", errcnt); end
    rdvld = 1'b1; rdaddr = 16'hF000;
    for (int i = 0; i < 300; i++) @(negedge clk);
    rdvld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (errcnt !== 8'hFF) begin n_err++; $display("FAIL oor_errcnt_sat: got %h want ff", errcnt); end
`endif
  endtask

  task automatic test_reset_mid_resp;
    int x0;
    wrrdy = 1'b0;
    rdvld = 1'b1; rdaddr = 16'h2006; rddata = 32'h0000_5555;
    @(negedge clk);
    rdvld = 1'b0;
    n_cmp++;
    if (wrvld !== 1'b1 || wrdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL mid_resp_pending: got vld %b data %h want 1 deadbeef", wrvld, wrdata); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (wrvld !== 1'b0 || rdrdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_out: got vld %b rdrdy %b want 0 0", wrvld, rdrdy); end
    n_cmp++;
    if (regout !== 128'h0 || wrdata !== 32'h0 || wraddr !== 16'h0) begin
      n_err++; $display("FAIL mid_rst_state: got regs %h data %h addr %h want 0", regout, wrdata, wraddr);
    end
    rst = 1'b0; wrrdy = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wrvld !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_resp cyc %0d: got %b want 0", i, wrvld); end
    end
    n_cmp++;
    if (xfers != x0) begin n_err++; $display("FAIL mid_rst_xfers: got %0d want 0", xfers - x0); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_stall;
    test_back_to_back;
    test_out_of_range;
    test_reset_mid_resp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
